cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
Parametrised per-layer control FSM for the CNN datapath and the next generation of the single-layer controller. It owns the filter, input-channel and window counters internally instead of taking last_filter/done_all_windows from outside. It sequences stream → (channel-accumulate conv per filter) → store → shift for every window, then optionally runs pooling. It adds run-time pooling bypass, abort, and busy/done status, and sits between the line-buffer/window generator, the conv MAC unit, the result RAM and the pooling unit.

Parameters:
NUM_FILTERS, 4, filters applied per window (≥1)
NUM_CHANNELS, 1, input channels accumulated per filter (≥1)
NUM_WINDOWS, 676, output windows per feature map (≥1)
TIMEOUT_CYC, 1024, watchdog limit in cycles for the conv/pool wait states (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  level/pulse; begins a layer when idle
abort  in  1  synchronous abort to IDLE
pool_en  in  1  sampled at start; 1 = run pooling after last window
win_valid  in  1  window generator has a full window
conv_done  in  1  MAC finished current channel pass
pool_done  in  1  pooling unit finished
addr_clear  out  1  pulse: reset RAM/window address generators
acc_clear  out  1  pulse: clear MAC accumulator (before channel 0)
conv_start  out  1  pulse: start one channel pass
ram_we  out  1  pulse: write accumulated result
pool_start  out  1  pulse: start pooling
is_streaming  out  1  combinational, state==STREAM
is_shifting  out  1  combinational, state==SHIFT
filter_idx  out  max(1,clog2(NUM_FILTERS))  current filter
chan_idx  out  max(1,clog2(NUM_CHANNELS))  current channel
window_idx  out  max(1,clog2(NUM_WINDOWS))  current window
busy  out  1  high in every state except IDLE
done  out  1  pulse: layer complete (or aborted-by-timeout, see err)
err  out  1  sticky timeout flag; cleared by rst or next accepted start

Behaviour:
- Reset (rst=1 at an edge): state IDLE, all pulses 0, all indices 0, busy 0, done 0, err 0, pool_en latch 0.
- All pulse outputs are registered, cleared by default every cycle, and high for exactly one cycle.
- States: IDLE, STREAM, SHIFT, SETUP, CONV_GO, CONV_WAIT, STORE, CHECK, POOL_GO, POOL_WAIT, FINISH.
- IDLE: when start=1, assert addr_clear, zero all indices, latch pool_en, clear err, go to STREAM. start is ignored in every other state.
- STREAM: wait for win_valid → SETUP. SHIFT: one cycle → STREAM.
- SETUP: when chan_idx==0, assert acc_clear. → CONV_GO.
- CONV_GO: assert conv_start. → CONV_WAIT. CONV_WAIT: conv_done → STORE. conv_done outside CONV_WAIT is ignored.
- STORE: when chan_idx==NUM_CHANNELS-1, assert ram_we with filter_idx/window_idx held stable in the same cycle; otherwise no write. → CHECK.
- CHECK, evaluated in priority order:
  (a) chan_idx<NUM_CHANNELS-1: chan_idx++ → SETUP.
  (b) filter_idx<NUM_FILTERS-1: chan_idx=0, filter_idx++ → SETUP.
  (c) window_idx<NUM_WINDOWS-1: chan_idx=0, filter_idx=0, window_idx++ → SHIFT.
  (d) last window: → POOL_GO if pool_en latched, else FINISH. Indices are not incremented.
- POOL_GO: assert pool_start → POOL_WAIT. POOL_WAIT: pool_done → FINISH.
- FINISH: assert done → IDLE.
- Counters never wrap mid-layer. Each index resets to 0 only via the rule that advances the next-outer counter, at start, or by reset.
- abort=1 in any non-IDLE state: next state IDLE; no pulse issued that cycle; no done; indices hold their value for debug. abort in IDLE: no effect. rst has priority over abort, and abort over every state transition.
- Per layer: conv_start count = F·C·W, ram_we count = F·W, acc_clear count = F·W, pool_start count ≤ 1, done count = 1.
- Latency: start→addr_clear 1 cycle. With zero-wait conv_done and pool_done, one filter pass costs 5 cycles per channel.

Optional Feature:
SEQ_TIMEOUT_EN — when defined, a counter runs in CONV_WAIT and POOL_WAIT and reloads on entering either state. If it reaches TIMEOUT_CYC before the awaited done arrives, the block sets err=1, pulses done, and goes to IDLE. When not defined, there is no counter, err is tied to 0, and the wait states wait indefinitely.

Test Plan:
- F=2, C=3, W=4, pool_en=1, conv_done 2 cycles after conv_start, immediate win_valid/pool_done → 24 conv_start, 8 ram_we, 8 acc_clear, 3 is_shifting cycles, 1 pool_start, 1 done, busy falls with done.
- Same config, pool_en=0 → no pool_start; done 1 cycle after the last CHECK; pool_en toggled mid-layer has no effect.
- ram_we capture: each write carries (window_idx, filter_idx) in order (0,0),(0,1),(1,0)…(3,1); chan_idx==2 at every ram_we.
- abort asserted in the 2nd CONV_WAIT → IDLE next cycle, no done, no ram_we; a new start then gives addr_clear and indices 0.
- start held high for a whole layer → exactly one layer run; rst pulsed mid-STREAM → all outputs 0 on the next cycle.
- SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, conv_done never asserted → err=1 and a done pulse exactly 16 cycles after CONV_WAIT entry; err clears on the next start.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Per-layer CNN control FSM: owns the filter/channel/window counters and runs
// stream -> conv (per channel, per filter) -> store -> shift per window, then optional pooling.
// Define SEQ_TIMEOUT_EN to add a watchdog on the conv/pool wait states (sets o_err, ends the layer).
module cnn_layer_sequencer #(
    parameter int NUM_FILTERS  = 4,
    parameter int NUM_CHANNELS = 1,
    parameter int NUM_WINDOWS  = 676,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_pool_en,
    input  logic i_win_valid,
    input  logic i_conv_done,
    input  logic i_pool_done,
    output logic o_addr_clear,
    output logic o_acc_clear,
    output logic o_conv_start,
    output logic o_ram_we,
    output logic o_pool_start,
    output logic o_is_streaming,
    output logic o_is_shifting,
    output logic [((NUM_FILTERS  > 1) ? $clog2(NUM_FILTERS)  : 1)-1:0] o_filter_idx,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] o_chan_idx,
    output logic [((NUM_WINDOWS  > 1) ? $clog2(NUM_WINDOWS)  : 1)-1:0] o_window_idx,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);
    localparam int FW = (NUM_FILTERS  > 1) ? $clog2(NUM_FILTERS)  : 1;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int WW = (NUM_WINDOWS  > 1) ? $clog2(NUM_WINDOWS)  : 1;
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CHANNELS - 1);
    localparam logic [WW-1:0] W_LAST = WW'(NUM_WINDOWS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_STREAM, S_SHIFT, S_SETUP, S_CONV_GO, S_CONV_WAIT,
        S_STORE, S_CHECK, S_POOL_GO, S_POOL_WAIT, S_FINISH
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_addr_clear, w_addr_clear_nxt;
    logic            r_acc_clear, w_acc_clear_nxt;
    logic            r_conv_start, w_conv_start_nxt;
    logic            r_ram_we, w_ram_we_nxt;
    logic            r_pool_start, w_pool_start_nxt;
    logic            r_done, w_done_nxt;
    logic            r_pool_en, w_pool_en_nxt;
    logic [FW-1:0]   r_filter, w_filter_nxt;
    logic [CW-1:0]   r_chan, w_chan_nxt;
    logic [WW-1:0]   r_window, w_window_nxt;
`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic            r_err, w_err_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr_clear <= 1'b0;
            r_acc_clear  <= 1'b0;
            r_conv_start <= 1'b0;
            r_ram_we     <= 1'b0;
            r_pool_start <= 1'b0;
            r_done       <= 1'b0;
            r_pool_en    <= 1'b0;
            r_filter     <= '0;
            r_chan       <= '0;
            r_window     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr_clear <= w_addr_clear_nxt;
            r_acc_clear  <= w_acc_clear_nxt;
            r_conv_start <= w_conv_start_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_pool_start <= w_pool_start_nxt;
            r_done       <= w_done_nxt;
            r_pool_en    <= w_pool_en_nxt;
            r_filter     <= w_filter_nxt;
            r_chan       <= w_chan_nxt;
            r_window     <= w_window_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
            r_tmo <= '0;
        end else begin
            r_err <= w_err_nxt;
            r_tmo <= w_tmo_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_clear_nxt = 1'b0;
        w_acc_clear_nxt  = 1'b0;
        w_conv_start_nxt = 1'b0;
        w_ram_we_nxt     = 1'b0;
        w_pool_start_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_pool_en_nxt    = r_pool_en;
        w_filter_nxt     = r_filter;
        w_chan_nxt       = r_chan;
        w_window_nxt     = r_window;
`ifdef SEQ_TIMEOUT_EN
        w_err_nxt        = r_err;
        w_tmo_nxt        = r_tmo;
`endif
        // Abort wins over every transition; indices are left intact for debug.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_addr_clear_nxt = 1'b1;
                        w_filter_nxt     = '0;
                        w_chan_nxt       = '0;
                        w_window_nxt     = '0;
                        w_pool_en_nxt    = i_pool_en;
`ifdef SEQ_TIMEOUT_EN
                        w_err_nxt        = 1'b0;
`endif
                        w_state_nxt      = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (i_win_valid) w_state_nxt = S_SETUP;
                end
                S_SHIFT: w_state_nxt = S_STREAM;
                S_SETUP: begin
                    if (r_chan == '0) w_acc_clear_nxt = 1'b1;
                    w_state_nxt = S_CONV_GO;
                end
                S_CONV_GO: begin
                    w_conv_start_nxt = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    w_tmo_nxt        = '0;
`endif
                    w_state_nxt      = S_CONV_WAIT;
                end
                S_CONV_WAIT: begin
                    if (i_conv_done) w_state_nxt = S_STORE;
`ifdef SEQ_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else w_tmo_nxt = r_tmo + TW'(1);
`endif
                end
                S_STORE: begin
                    if (r_chan == C_LAST) w_ram_we_nxt = 1'b1;
                    w_state_nxt = S_CHECK;
                end
                S_CHECK: begin
                    if (r_chan < C_LAST) begin
                        w_chan_nxt  = r_chan + CW'(1);
                        w_state_nxt = S_SETUP;
                    end else if (r_filter < F_LAST) begin
                        w_chan_nxt   = '0;
                        w_filter_nxt = r_filter + FW'(1);
                        w_state_nxt  = S_SETUP;
                    end else if (r_window < W_LAST) begin
                        w_chan_nxt   = '0;
                        w_filter_nxt = '0;
                        w_window_nxt = r_window + WW'(1);
                        w_state_nxt  = S_SHIFT;
                    end else begin
                        w_state_nxt = r_pool_en ? S_POOL_GO : S_FINISH;
                    end
                end
                S_POOL_GO: begin
                    w_pool_start_nxt = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    w_tmo_nxt        = '0;
`endif
                    w_state_nxt      = S_POOL_WAIT;
                end
                S_POOL_WAIT: begin
                    if (i_pool_done) w_state_nxt = S_FINISH;
`ifdef SEQ_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else w_tmo_nxt = r_tmo + TW'(1);
`endif
                end
                S_FINISH: begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_addr_clear   = r_addr_clear;
    assign o_acc_clear    = r_acc_clear;
    assign o_conv_start   = r_conv_start;
    assign o_ram_we       = r_ram_we;
    assign o_pool_start   = r_pool_start;
    assign o_done         = r_done;
    assign o_filter_idx   = r_filter;
    assign o_chan_idx     = r_chan;
    assign o_window_idx   = r_window;
    assign o_is_streaming = (r_state == S_STREAM);
    assign o_is_shifting  = (r_state == S_SHIFT);
    assign o_busy         = (r_state != S_IDLE);
`ifdef SEQ_TIMEOUT_EN
    assign o_err          = r_err;
`else
    assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer (F=2, C=3, W=4): table of whole-layer runs plus
// directed abort, reset and (with SEQ_TIMEOUT_EN) watchdog sequences.
module tb_cnn_layer_sequencer;
    localparam int F  = 2;
    localparam int C  = 3;
    localparam int W  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, pool_en = 1'b0, win_valid = 1'b0;
    logic conv_done = 1'b0, pool_done = 1'b0;
    logic addr_clear, acc_clear, conv_start, ram_we, pool_start;
    logic is_streaming, is_shifting, busy, done, err;
    logic [0:0] filter_idx;
    logic [1:0] chan_idx;
    logic [1:0] window_idx;

    cnn_layer_sequencer #(
        .NUM_FILTERS(F), .NUM_CHANNELS(C), .NUM_WINDOWS(W), .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_pool_en(pool_en), .i_win_valid(win_valid),
        .i_conv_done(conv_done), .i_pool_done(pool_done),
        .o_addr_clear(addr_clear), .o_acc_clear(acc_clear),
        .o_conv_start(conv_start), .o_ram_we(ram_we), .o_pool_start(pool_start),
        .o_is_streaming(is_streaming), .o_is_shifting(is_shifting),
        .o_filter_idx(filter_idx), .o_chan_idx(chan_idx), .o_window_idx(window_idx),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cd_lat = 2;
    bit cd_en = 1'b1;
    int cd_cnt = 0;
    int tot_conv = 0, tot_we = 0, tot_acc = 0, tot_shift = 0;
    int tot_pool = 0, tot_done = 0, tot_addr = 0;
    int wq[$];

    // Conv MAC and pooling unit stand-ins: conv_done cd_lat cycles after conv_start.
    always @(negedge clk) begin
        conv_done = 1'b0;
        if (cd_en && conv_start) begin
            if (cd_lat == 0) conv_done = 1'b1;
            else cd_cnt = cd_lat;
        end else if (cd_cnt > 0) begin
            cd_cnt = cd_cnt - 1;
            if (cd_cnt == 0) conv_done = 1'b1;
        end
        pool_done = pool_start;
    end

    always @(negedge clk) begin
        if (conv_start)  tot_conv++;
        if (ram_we)      tot_we++;
        if (acc_clear)   tot_acc++;
        if (is_shifting) tot_shift++;
        if (pool_start)  tot_pool++;
        if (done)        tot_done++;
        if (addr_clear)  tot_addr++;
        if (ram_we) wq.push_back(int'(window_idx) * 100 + int'(filter_idx) * 10 + int'(chan_idx));
    end

    function automatic int outs();
        return int'({addr_clear, acc_clear, conv_start, ram_we, pool_start, is_streaming,
                     is_shifting, busy, done, err, window_idx, filter_idx, chan_idx});
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    typedef struct {
        bit pe; int lat; bit tog; bit hold;
        int e_conv; int e_we; int e_acc; int e_shift; int e_pool; int e_done; int e_cyc;
    } vec_t;

    vec_t vt[4];
    int   b_conv, b_we, b_acc, b_shift, b_pool, b_done, b_addr, bq;
    int   k, seen;
    bit   got, prev_busy, busy_at_done;

    initial begin
        vt[0] = '{1'b1, 2, 1'b0, 1'b0, 24, 8, 8, 3, 1, 1, 178};
        vt[1] = '{1'b0, 2, 1'b1, 1'b0, 24, 8, 8, 3, 0, 1, 176};
        vt[2] = '{1'b1, 0, 1'b1, 1'b0, 24, 8, 8, 3, 1, 1, 130};
        vt[3] = '{1'b0, 0, 1'b0, 1'b1, 24, 8, 8, 3, 0, 1, 128};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs(), 0);

        for (int i = 0; i < 4; i++) begin
            cd_lat = vt[i].lat; pool_en = vt[i].pe; win_valid = 1'b1;
            b_conv = tot_conv; b_we = tot_we; b_acc = tot_acc; b_shift = tot_shift;
            b_pool = tot_pool; b_done = tot_done; b_addr = tot_addr; bq = wq.size();
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 if (!vt[i].hold) start = 1'b0;
            k = 1; got = 1'b0; prev_busy = 1'b0; busy_at_done = 1'b1;
            while (k <= 1000) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1; busy_at_done = busy; start = 1'b0;
                    break;
                end
                if (vt[i].tog && k == 20) pool_en = ~pool_en;
                prev_busy = busy;
                k++;
            end
            check($sformatf("v%0d_done_seen", i), int'(got), 1);
            check($sformatf("v%0d_cycles", i), k - 1, vt[i].e_cyc);
            check($sformatf("v%0d_busy_before_done", i), int'(prev_busy), 1);
            check($sformatf("v%0d_busy_at_done", i), int'(busy_at_done), 0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_idle_after", i), int'(busy), 0);
            check($sformatf("v%0d_err", i), int'(err), 0);
            check($sformatf("v%0d_conv_start", i), tot_conv - b_conv, vt[i].e_conv);
            check($sformatf("v%0d_ram_we", i), tot_we - b_we, vt[i].e_we);
            check($sformatf("v%0d_acc_clear", i), tot_acc - b_acc, vt[i].e_acc);
            check($sformatf("v%0d_shift_cycles", i), tot_shift - b_shift, vt[i].e_shift);
            check($sformatf("v%0d_pool_start", i), tot_pool - b_pool, vt[i].e_pool);
            check($sformatf("v%0d_done_count", i), tot_done - b_done, vt[i].e_done);
            check($sformatf("v%0d_addr_clear", i), tot_addr - b_addr, 1);
            for (int r = 0; r < F * W; r++) begin
                if (bq + r < wq.size())
                    check($sformatf("v%0d_we_rec%0d", i, r), wq[bq + r],
                          (r / F) * 100 + (r % F) * 10 + (C - 1));
                else
                    check($sformatf("v%0d_we_rec%0d_missing", i, r), wq.size() - bq, F * W);
            end
        end

        // Abort in the second CONV_WAIT, then a fresh start.
        cd_lat = 2; pool_en = 1'b0; win_valid = 1'b1;
        b_we = tot_we; b_done = tot_done;
        pulse_start();
        seen = 0; k = 0;
        while (k < 200 && seen < 2) begin
            @(negedge clk); k++;
            if (conv_start) seen++;
        end
        check("abort_reached_2nd_conv", seen, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_idx_held", int'({window_idx, filter_idx, chan_idx}), 1);
        repeat (10) @(negedge clk);
        check("abort_no_ram_we", tot_we - b_we, 0);
        check("abort_no_done", tot_done - b_done, 0);
        pulse_start();
        @(negedge clk);
        check("restart_addr_clear", int'(addr_clear), 1);
        check("restart_idx_zero", int'({window_idx, filter_idx, chan_idx}), 0);
        check("restart_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_stream", int'(busy), 0);

        // Reset while streaming window 1.
        cd_lat = 0; win_valid = 1'b1;
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (is_shifting) begin got = 1'b1; break; end
        end
        check("rst_reached_shift", int'(got), 1);
        win_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_stream", int'(is_streaming), 1);
        check("rst_pre_window", int'(window_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_stream_outputs", outs(), 0);
        win_valid = 1'b1;

`ifdef SEQ_TIMEOUT_EN
        cd_en = 1'b0; cd_cnt = 0;
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (conv_start) begin got = 1'b1; break; end
        end
        check("tmo_conv_wait_entered", int'(got), 1);
        k = 0; got = 1'b0;
        while (k < 100) begin
            @(negedge clk); k++;
            if (done) begin got = 1'b1; break; end
        end
        check("tmo_done_seen", int'(got), 1);
        check("tmo_latency", k, TO);
        check("tmo_err_set", int'(err), 1);
        check("tmo_busy", int'(busy), 0);
        @(negedge clk);
        check("tmo_err_sticky", int'(err), 1);
        cd_en = 1'b1;
        pulse_start();
        @(negedge clk);
        check("tmo_err_cleared", int'(err), 0);
        check("tmo_restart_addr_clear", int'(addr_clear), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
